// File: rtl/running_max_ctrl.sv
// running_max_ctrl: holds the running row maximum for the online-softmax max loop,
// bypasses it back to the max stage and forwards (s, m) pairs through a one-entry
// registered slot, tagging the last key of every query row.
module running_max_ctrl #(
    parameter int unsigned  NUM_KEYS = 64,
    parameter int unsigned  DATA_W   = 8,
    localparam int unsigned CNT_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     vld_in,
    output logic                     rdy_out,
    input  logic signed [DATA_W-1:0] s_in,
    input  logic signed [DATA_W-1:0] m_in,
    output logic signed [DATA_W-1:0] m_prev_out,
    output logic                     vld_out,
    input  logic                     rdy_in,
    output logic signed [DATA_W-1:0] s_out,
    output logic signed [DATA_W-1:0] m_out,
    output logic                     last_out,
    output logic [CNT_W-1:0]         key_idx,
    output logic                     mono_err
);

    localparam logic [CNT_W-1:0]         LAST_IDX = CNT_W'(NUM_KEYS - 1);
    localparam logic signed [DATA_W-1:0] INT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

    logic                     vld_q, vld_d;
    logic signed [DATA_W-1:0] s_q, s_d;
    logic signed [DATA_W-1:0] m_q, m_d;
    logic                     last_q, last_d;
    logic [CNT_W-1:0]         idx_q, idx_d;
    logic signed [DATA_W-1:0] run_max_q, run_max_d;
    logic                     mono_q, mono_d;

    logic rdy_c;
    logic acc_c;
    logic last_key_c;

    // Handshake: the slot accepts when empty or when it drains this same cycle.
    always_comb begin
        rdy_c      = !vld_q || rdy_in;
        acc_c      = vld_in && rdy_c;
        last_key_c = (idx_q == LAST_IDX);
    end

    // Same-cycle bypass so a score latched on this edge sees the freshest max.
    always_comb begin
        m_prev_out = run_max_q;
        if (acc_c) begin
            m_prev_out = last_key_c ? INT_MIN : m_in;
        end
    end

    // Next-state for the output slot, row counter, running max and error flag.
    always_comb begin
        vld_d     = vld_q;
        s_d       = s_q;
        m_d       = m_q;
        last_d    = last_q;
        idx_d     = idx_q;
        run_max_d = run_max_q;
        mono_d    = mono_q;

        if (acc_c) begin
            vld_d  = 1'b1;
            s_d    = s_in;
            m_d    = m_in;
            last_d = last_key_c;
            if (last_key_c) begin
                idx_d     = '0;
                run_max_d = INT_MIN;
            end else begin
                idx_d     = idx_q + CNT_W'(1);
                run_max_d = m_in;
            end
            if ((idx_q != '0) && (m_in < run_max_q)) begin
                mono_d = 1'b1;
            end
        end else if (vld_q && rdy_in) begin
            vld_d  = 1'b0;
            last_d = 1'b0;
        end
    end

    // State registers with synchronous reset; reset drops any partial row.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q     <= 1'b0;
            s_q       <= '0;
            m_q       <= '0;
            last_q    <= 1'b0;
            idx_q     <= '0;
            run_max_q <= INT_MIN;
            mono_q    <= 1'b0;
        end else begin
            vld_q     <= vld_d;
            s_q       <= s_d;
            m_q       <= m_d;
            last_q    <= last_d;
            idx_q     <= idx_d;
            run_max_q <= run_max_d;
            mono_q    <= mono_d;
        end
    end

    assign rdy_out  = rdy_c;
    assign vld_out  = vld_q;
    assign s_out    = s_q;
    assign m_out    = m_q;
    assign last_out = last_q;
    assign key_idx  = idx_q;
    assign mono_err = mono_q;

endmodule

// File: tb/tb_running_max_ctrl.sv
// Testbench for running_max_ctrl: directed scenarios plus randomized traffic
// against a queue-based row/slot reference model (NUM_KEYS=4, 8-bit scores).
module tb_running_max_ctrl;

    localparam int unsigned NK = 4;
    localparam int unsigned DW = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 vld_in;
    logic                 rdy_out;
    logic signed [DW-1:0] s_in;
    logic signed [DW-1:0] m_in;
    logic signed [DW-1:0] m_prev_out;
    logic                 vld_out;
    logic                 rdy_in;
    logic signed [DW-1:0] s_out;
    logic signed [DW-1:0] m_out;
    logic                 last_out;
    logic [1:0]           key_idx;
    logic                 mono_err;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int s;
        int m;
        bit last;
    } pair_t;

    int    row_m[$];
    pair_t out_q[$];
    bit    merr;

    running_max_ctrl #(.NUM_KEYS(NK), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .vld_in     (vld_in),
        .rdy_out    (rdy_out),
        .s_in       (s_in),
        .m_in       (m_in),
        .m_prev_out (m_prev_out),
        .vld_out    (vld_out),
        .rdy_in     (rdy_in),
        .s_out      (s_out),
        .m_out      (m_out),
        .last_out   (last_out),
        .key_idx    (key_idx),
        .mono_err   (mono_err)
    );

    always #5 clk = ~clk;

    // One reset edge; returns 1 time unit after that edge with rst released.
    task automatic do_reset();
        rst = 1'b1; vld_in = 1'b0; rdy_in = 1'b0; s_in = '0; m_in = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        row_m.delete(); out_q.delete(); merr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; vld_in = 1'b0; rdy_in = 1'b1; s_in = 8'(11); m_in = 8'(22);
        @(posedge clk); #1;
        rst = 1'b0; #1;
        n_chk++; if (m_prev_out !== -128) $display("FAIL reset_m_prev: got %0d want -128", m_prev_out); else n_pass++;
        n_chk++; if (vld_out !== 1'b0) $display("FAIL reset_vld_out: got %b want 0", vld_out); else n_pass++;
        n_chk++; if (int'(key_idx) !== 0) $display("FAIL reset_key_idx: got %0d want 0", key_idx); else n_pass++;
        n_chk++; if (mono_err !== 1'b0) $display("FAIL reset_mono_err: got %b want 0", mono_err); else n_pass++;
        n_chk++; if (rdy_out !== 1'b1) $display("FAIL reset_rdy_out: got %b want 1", rdy_out); else n_pass++;
        n_chk++; if (last_out !== 1'b0 || s_out !== 0 || m_out !== 0) $display("FAIL reset_data: got last=%b s=%0d m=%0d want 0/0/0", last_out, s_out, m_out); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        int ps[4] = '{3, -5, 7, 2};
        int pm[4] = '{3, 3, 7, 7};
        int mp[4] = '{3, 3, 7, -128};
        do_reset();
        rdy_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vld_in = 1'b1; s_in = 8'(ps[i]); m_in = 8'(pm[i]); #1;
            n_chk++; if (int'(key_idx) !== i) $display("FAIL stream_key_idx[%0d]: got %0d want %0d", i, key_idx, i); else n_pass++;
            n_chk++; if (int'(m_prev_out) !== mp[i]) $display("FAIL stream_m_prev[%0d]: got %0d want %0d", i, m_prev_out, mp[i]); else n_pass++;
            n_chk++; if (rdy_out !== 1'b1) $display("FAIL stream_rdy_out[%0d]: got %b want 1", i, rdy_out); else n_pass++;
            @(posedge clk); #1;
            n_chk++; if (vld_out !== 1'b1) $display("FAIL stream_vld_out[%0d]: got %b want 1", i, vld_out); else n_pass++;
            n_chk++; if (int'(s_out) !== ps[i] || int'(m_out) !== pm[i]) $display("FAIL stream_data[%0d]: got %0d/%0d want %0d/%0d", i, s_out, m_out, ps[i], pm[i]); else n_pass++;
            n_chk++; if (last_out !== (i == 3)) $display("FAIL stream_last[%0d]: got %b want %b", i, last_out, (i == 3)); else n_pass++;
        end
        vld_in = 1'b0; #1;
        n_chk++; if (int'(key_idx) !== 0) $display("FAIL stream_key_wrap: got %0d want 0", key_idx); else n_pass++;
        n_chk++; if (m_prev_out !== -128) $display("FAIL stream_m_prev_idle: got %0d want -128", m_prev_out); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if (vld_out !== 1'b0 || last_out !== 1'b0) $display("FAIL stream_drain: got vld=%b last=%b want 0/0", vld_out, last_out); else n_pass++;
    endtask

    task automatic test_backpressure();
        do_reset();
        vld_in = 1'b1; rdy_in = 1'b0; s_in = 8'(4); m_in = 8'(4);
        @(posedge clk); #1;
        s_in = 8'(6); m_in = 8'(6);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if (rdy_out !== 1'b0) $display("FAIL bp_rdy_out[%0d]: got %b want 0", i, rdy_out); else n_pass++;
            n_chk++; if (m_prev_out !== 4) $display("FAIL bp_m_prev[%0d]: got %0d want 4", i, m_prev_out); else n_pass++;
            @(posedge clk); #1;
            n_chk++; if (vld_out !== 1'b1 || s_out !== 4 || m_out !== 4) $display("FAIL bp_hold[%0d]: got vld=%b s=%0d m=%0d want 1/4/4", i, vld_out, s_out, m_out); else n_pass++;
            n_chk++; if (int'(key_idx) !== 1) $display("FAIL bp_key_idx[%0d]: got %0d want 1", i, key_idx); else n_pass++;
        end
        rdy_in = 1'b1; #1;
        n_chk++; if (rdy_out !== 1'b1) $display("FAIL bp_release_rdy: got %b want 1", rdy_out); else n_pass++;
        n_chk++; if (m_prev_out !== 6) $display("FAIL bp_release_m_prev: got %0d want 6", m_prev_out); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if (vld_out !== 1'b1 || s_out !== 6 || m_out !== 6) $display("FAIL bp_no_bubble: got vld=%b s=%0d m=%0d want 1/6/6", vld_out, s_out, m_out); else n_pass++;
        n_chk++; if (int'(key_idx) !== 2) $display("FAIL bp_key_after: got %0d want 2", key_idx); else n_pass++;
        vld_in = 1'b0;
        @(posedge clk); #1;
        n_chk++; if (vld_out !== 1'b0) $display("FAIL bp_drain: got %b want 0", vld_out); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int ps[8] = '{1, 5, 2, 0, -9, -3, -20, 4};
        int pm[8] = '{1, 5, 5, 5, -9, -3, -3, 4};
        int mp[8] = '{1, 5, 5, -128, -9, -3, -3, -128};
        do_reset();
        rdy_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vld_in = 1'b1; s_in = 8'(ps[i]); m_in = 8'(pm[i]); #1;
            n_chk++; if (int'(m_prev_out) !== mp[i]) $display("FAIL b2b_m_prev[%0d]: got %0d want %0d", i, m_prev_out, mp[i]); else n_pass++;
            @(posedge clk); #1;
            n_chk++; if (vld_out !== 1'b1 || int'(s_out) !== ps[i] || int'(m_out) !== pm[i]) $display("FAIL b2b_data[%0d]: got vld=%b %0d/%0d want 1 %0d/%0d", i, vld_out, s_out, m_out, ps[i], pm[i]); else n_pass++;
            n_chk++; if (last_out !== (i == 3 || i == 7)) $display("FAIL b2b_last[%0d]: got %b want %b", i, last_out, (i == 3 || i == 7)); else n_pass++;
            if (i == 3) begin
                vld_in = 1'b0; #1;
                n_chk++; if (m_prev_out !== -128) $display("FAIL b2b_row_start_m_prev: got %0d want -128", m_prev_out); else n_pass++;
            end
        end
        vld_in = 1'b0; #1;
        n_chk++; if (mono_err !== 1'b0) $display("FAIL b2b_mono_err: got %b want 0", mono_err); else n_pass++;
        n_chk++; if (int'(key_idx) !== 0 || m_prev_out !== -128) $display("FAIL b2b_end: got idx=%0d m_prev=%0d want 0/-128", key_idx, m_prev_out); else n_pass++;
    endtask

    task automatic test_mono_err();
        do_reset();
        rdy_in = 1'b1; vld_in = 1'b1; s_in = 8'(5); m_in = 8'(5);
        @(posedge clk); #1;
        n_chk++; if (mono_err !== 1'b0) $display("FAIL mono_first: got %b want 0", mono_err); else n_pass++;
        s_in = 8'(1); m_in = 8'(2);
        @(posedge clk); #1;
        n_chk++; if (mono_err !== 1'b1) $display("FAIL mono_set: got %b want 1", mono_err); else n_pass++;
        n_chk++; if (s_out !== 1 || m_out !== 2 || vld_out !== 1'b1) $display("FAIL mono_forward: got vld=%b %0d/%0d want 1 1/2", vld_out, s_out, m_out); else n_pass++;
        vld_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (mono_err !== 1'b1) $display("FAIL mono_sticky: got %b want 1", mono_err); else n_pass++;
    endtask

    task automatic test_reset_midrow();
        do_reset();
        rdy_in = 1'b1; vld_in = 1'b1; s_in = 8'(5); m_in = 8'(5);
        @(posedge clk); #1;
        s_in = 8'(1); m_in = 8'(2);
        @(posedge clk); #1;
        vld_in = 1'b0; rdy_in = 1'b0; #1;
        n_chk++; if (vld_out !== 1'b1 || int'(key_idx) !== 2 || mono_err !== 1'b1) $display("FAIL midrow_pre: got vld=%b idx=%0d err=%b want 1/2/1", vld_out, key_idx, mono_err); else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; #1;
        n_chk++; if (vld_out !== 1'b0) $display("FAIL midrow_vld_out: got %b want 0", vld_out); else n_pass++;
        n_chk++; if (int'(key_idx) !== 0) $display("FAIL midrow_key_idx: got %0d want 0", key_idx); else n_pass++;
        n_chk++; if (m_prev_out !== -128) $display("FAIL midrow_m_prev: got %0d want -128", m_prev_out); else n_pass++;
        n_chk++; if (mono_err !== 1'b0) $display("FAIL midrow_mono_err: got %b want 0", mono_err); else n_pass++;
        @(posedge clk); #1;
    endtask

    // Random traffic; the model tracks the row as a list of accepted maxima and the slot as a queue.
    task automatic test_random(input int n, input bit allow_bad);
        bit v, r, acc;
        int s, m, run, mp_e;
        bit rdy_e;
        do_reset();
        for (int i = 0; i < n; i++) begin
            v   = ($urandom_range(0, 9) < 7);
            r   = ($urandom_range(0, 9) < 7);
            s   = int'($urandom_range(0, 255)) - 128;
            run = (row_m.size() == 0) ? -128 : row_m[$];
            if (allow_bad && $urandom_range(0, 15) == 0) m = int'($urandom_range(0, 255)) - 128;
            else m = (s > run) ? s : run;
            vld_in = v; rdy_in = r; s_in = 8'(s); m_in = 8'(m); #1;
            rdy_e = (out_q.size() == 0) || r;
            acc   = v && rdy_e;
            mp_e  = acc ? ((row_m.size() == NK - 1) ? -128 : m) : run;
            n_chk++; if (rdy_out !== rdy_e) $display("FAIL rand_rdy_out[%0d]: got %b want %b", i, rdy_out, rdy_e); else n_pass++;
            n_chk++; if (int'(m_prev_out) !== mp_e) $display("FAIL rand_m_prev[%0d]: got %0d want %0d", i, m_prev_out, mp_e); else n_pass++;
            @(posedge clk); #1;
            if (r && out_q.size() != 0) void'(out_q.pop_front());
            if (acc) begin
                if (row_m.size() != 0 && m < run) merr = 1'b1;
                out_q.push_back('{s: s, m: m, last: (row_m.size() == NK - 1)});
                row_m.push_back(m);
                if (row_m.size() == NK) row_m.delete();
            end
            n_chk++; if (vld_out !== (out_q.size() != 0)) $display("FAIL rand_vld_out[%0d]: got %b want %b", i, vld_out, (out_q.size() != 0)); else n_pass++;
            if (out_q.size() != 0) begin
                n_chk++; if (int'(s_out) !== out_q[0].s || int'(m_out) !== out_q[0].m || last_out !== out_q[0].last)
                    $display("FAIL rand_slot[%0d]: got %0d/%0d/%b want %0d/%0d/%b", i, s_out, m_out, last_out, out_q[0].s, out_q[0].m, out_q[0].last);
                else n_pass++;
            end else begin
                n_chk++; if (last_out !== 1'b0) $display("FAIL rand_last_idle[%0d]: got %b want 0", i, last_out); else n_pass++;
            end
            n_chk++; if (int'(key_idx) !== row_m.size()) $display("FAIL rand_key_idx[%0d]: got %0d want %0d", i, key_idx, row_m.size()); else n_pass++;
            n_chk++; if (mono_err !== merr) $display("FAIL rand_mono_err[%0d]: got %b want %b", i, mono_err, merr); else n_pass++;
        end
        vld_in = 1'b0;
    endtask

    initial begin
        rst = 1'b0; vld_in = 1'b0; rdy_in = 1'b0; s_in = '0; m_in = '0;
        #2;
        test_reset();
        test_stream();
        test_backpressure();
        test_back_to_back();
        test_mono_err();
        test_reset_midrow();
        test_random(600, 1'b0);
        test_random(600, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
